// File: rtl/bus_decode_pkg.sv
// Shared types and defaults for the bus region decoder: FSM encoding,
// select-width helper and the default per-region wait table.
package bus_decode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam int DEF_NUM_REGIONS = 4;
    localparam int DEF_WAIT_W      = 3;

    // Region 0 is the least significant field.
    localparam logic [DEF_NUM_REGIONS*DEF_WAIT_W-1:0] DEF_WAIT_CYCLES =
        {3'd3, 3'd0, 3'd1, 3'd0};

    // Index width for n regions, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_region_lookup.sv
// Combinational address-to-region lookup: region index, mapped flag and the
// wait count configured for that region.
module bus_region_lookup
    import bus_decode_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int REGION_BITS = 13,
    parameter int WAIT_W      = DEF_WAIT_W,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] WAIT_CYCLES = DEF_WAIT_CYCLES,
    localparam int PAGE_W     = ADDR_W - REGION_BITS,
    localparam int SEL_W      = sel_width(NUM_REGIONS)
) (
    input  logic [PAGE_W-1:0] i_page,
    output logic [SEL_W-1:0]  o_region,
    output logic              o_mapped,
    output logic [WAIT_W-1:0] o_wait
);

    assign o_region = i_page[SEL_W-1:0];

    // One extra bit so NUM_REGIONS == 2**PAGE_W still compares correctly.
    assign o_mapped = ({1'b0, i_page} < (PAGE_W+1)'(NUM_REGIONS));

    always_comb begin
        o_wait = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (o_region == SEL_W'(i)) begin
                o_wait = WAIT_CYCLES[i*WAIT_W +: WAIT_W];
            end
        end
    end

endmodule

// File: rtl/bus_region_decoder.sv
// Handshaked region decoder: accepts one address, drives that region's
// active-low select for WAIT+1 cycles, or pulses bus_error when unmapped.
module bus_region_decoder
    import bus_decode_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int REGION_BITS = 13,
    parameter int WAIT_W      = DEF_WAIT_W,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] WAIT_CYCLES = DEF_WAIT_CYCLES,
    localparam int SEL_W      = sel_width(NUM_REGIONS)
) (
    input  logic                   clk,
    input  logic                   nRESET,
    input  logic                   req_valid,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   req_ready,
    output logic [NUM_REGIONS-1:0] cs_n,
    output logic [SEL_W-1:0]       active_select,
    output logic                   done_valid,
    output logic                   bus_error,
    output logic                   busy,
    output state_t                 dbg_state
);

    state_t                 r_state, w_next_state;
    logic [WAIT_W-1:0]      r_wait, w_wait_nxt;
    logic [NUM_REGIONS-1:0] r_cs_n, w_cs_n_nxt;
    logic [SEL_W-1:0]       r_sel, w_sel_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_err, w_err_nxt;

    logic [SEL_W-1:0]       w_region;
    logic                   w_mapped;
    logic [WAIT_W-1:0]      w_wait;
    logic                   w_unused_offset;

    // Offset bits inside a region never influence the decode.
    assign w_unused_offset = ^req_addr[REGION_BITS-1:0];

    bus_region_lookup #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BITS (REGION_BITS),
        .WAIT_W      (WAIT_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_lookup (
        .i_page   (req_addr[ADDR_W-1:REGION_BITS]),
        .o_region (w_region),
        .o_mapped (w_mapped),
        .o_wait   (w_wait)
    );

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_cs_n  <= '1;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sel   <= w_sel_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = w_mapped ? ACCESS : ERROR;
            ACCESS:  if (r_wait == '0) w_next_state = IDLE;
            ERROR:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_cs_n_nxt = '1;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_wait_nxt = r_wait;
        w_sel_nxt  = r_sel;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_mapped) begin
                        w_cs_n_nxt = ~(NUM_REGIONS'(1) << w_region);
                        w_sel_nxt  = w_region;
                        w_wait_nxt = w_wait;
                        w_done_nxt = (w_wait == '0);
                    end else begin
                        w_err_nxt  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // The select stays low until the counter has reached zero.
                if (r_wait != '0) begin
                    w_cs_n_nxt = r_cs_n;
                    w_wait_nxt = r_wait - 1'b1;
                    w_done_nxt = (r_wait == WAIT_W'(1));
                end
            end
            default: begin
            end
        endcase
    end

    assign req_ready     = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign cs_n          = r_cs_n;
    assign active_select = r_sel;
    assign done_valid    = r_done;
    assign bus_error     = r_err;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: per-cycle expected output vectors are
// queued when a request is driven and compared on each falling edge.
module tb_bus_region_decoder;
    import bus_decode_pkg::*;

    localparam int OBS_W = 12;

    logic        clk;
    logic        nRESET;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic [3:0]  cs_n;
    logic [1:0]  active_select;
    logic        done_valid;
    logic        bus_error;
    logic        busy;
    state_t      dut_state;

    logic [OBS_W-1:0] obs;
    logic [OBS_W-1:0] exp_q[$];
    int               n_cmp;
    int               n_fail;
    logic [1:0]       last_sel;
    int               wait_tbl[4] = '{0, 1, 0, 3};

    bus_region_decoder dut (
        .clk           (clk),
        .nRESET        (nRESET),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .cs_n          (cs_n),
        .active_select (active_select),
        .done_valid    (done_valid),
        .bus_error     (bus_error),
        .busy          (busy),
        .dbg_state     (dut_state)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cs_n, done, err, ready, busy, sel, state}
    assign obs = {cs_n, done_valid, bus_error, req_ready, busy, active_select, 2'(dut_state)};

    function automatic logic [OBS_W-1:0] ev(input logic [3:0] cs, input logic done,
                                            input logic err, input logic rdy,
                                            input logic bsy, input logic [1:0] sel,
                                            input logic [1:0] st);
        return {cs, done, err, rdy, bsy, sel, st};
    endfunction

    // ---- model: expected cycles for one request, closing with the IDLE cycle ----
    task automatic push_txn(input logic [15:0] addr);
        int         region;
        int         w;
        logic [3:0] cs;
        if (addr < 16'h8000) begin
            region = int'(addr) / 32'h2000;
            w      = wait_tbl[region];
            cs     = 4'b1111;
            cs[region] = 1'b0;
            last_sel = region[1:0];
            for (int i = 0; i <= w; i++) begin
                exp_q.push_back(ev(cs, (i == w), 1'b0, 1'b0, 1'b1, last_sel, 2'd1));
            end
        end else begin
            exp_q.push_back(ev(4'hF, 1'b0, 1'b1, 1'b0, 1'b1, last_sel, 2'd2));
        end
        exp_q.push_back(ev(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, last_sel, 2'd0));
    endtask

    // ---- scoreboard compare ----
    task automatic check_now(input string tag, input logic [OBS_W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cs_n,done,err,rdy,busy,sel,st)",
                   tag, obs, expv);
        end
    endtask

    task automatic check_next(input string tag);
        logic [OBS_W-1:0] expv;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed %b expected <empty queue>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            check_now(tag, expv);
        end
    endtask

    // ---- driver: one request, checked through its trailing IDLE cycle ----
    task automatic run_txn(input logic [15:0] addr, input string tag);
        req_valid = 1'b1;
        req_addr  = addr;
        push_txn(addr);
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (exp_q.size() > 0) check_next(tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        last_sel  = 2'd0;
        nRESET    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 16'h0000;

        // reset held for three cycles
        repeat (3) exp_q.push_back(ev(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        repeat (3) check_next("reset");
        nRESET = 1'b1;
        exp_q.push_back(ev(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        check_next("post_reset");

        run_txn(16'h1FFF, "region0_top");
        run_txn(16'h2000, "region1_wait1");
        run_txn(16'h6ABC, "region3_wait3");
        run_txn(16'h8000, "unmapped_8000");
        run_txn(16'hFFFF, "unmapped_ffff");

        // back-to-back: second address presented while busy
        req_valid = 1'b1;
        req_addr  = 16'h4000;
        push_txn(16'h4000);
        push_txn(16'h0000);
        @(posedge clk);
        #1 req_addr = 16'h0000;
        check_next("b2b_first");
        check_next("b2b_gap");
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_next("b2b_second");
        check_next("b2b_idle");

        for (int i = 0; i < 8; i++) begin
            run_txn(16'($urandom_range(0, 16'hFFFF)), "random");
        end

        // reset during the second select cycle of region 3
        req_valid = 1'b1;
        req_addr  = 16'h6000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) exp_q.push_back(ev(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1));
        check_next("abort_sel1");
        check_next("abort_sel2");
        #1 nRESET = 1'b0;
        #1 check_now("abort_async", ev(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        exp_q.delete();
        last_sel = 2'd0;
        repeat (2) exp_q.push_back(ev(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        repeat (2) check_next("abort_in_reset");
        nRESET = 1'b1;
        repeat (2) exp_q.push_back(ev(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
        repeat (2) check_next("abort_released");
        run_txn(16'h2345, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
